// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants, the FIFO entry type and the wrapping PC
//               increment used by the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int          ADDR_W_DEF   = 12;
  localparam int          DEPTH_DEF    = 2;
  localparam logic [31:0] RESET_PC_DEF = 32'd0;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fetch_entry_t;

  // PC + 1, wrapping modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry circular FIFO of fetch_entry_t. Flush empties the
//               FIFO and takes priority over a same-cycle push.
// Ports       : clk, reset   - clock, asynchronous active-high reset
//               push, push_data - write an entry at the tail
//               pop           - drop the head entry (ignored when empty)
//               flush         - discard all entries
//               count         - number of valid entries
//               head          - entry at the head (stale when count = 0)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output fetch_entry_t       head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q,  count_d;
  logic                   do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop = pop & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)   wr_ptr_d = ptr_next(wr_ptr_q);
      if (do_pop) rd_ptr_d = ptr_next(rd_ptr_q);
      case ({push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

`ifndef SYNTHESIS
  // The upstream issue rule keeps count + inflight <= DEPTH, so a push into
  // a full FIFO without a simultaneous pop means that rule was broken.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    (push && !flush) |-> ((count_q < CNT_W'(DEPTH)) || pop));
`endif

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the PC, issues word reads to a
//               1-cycle-latency instruction ROM, buffers the tagged results
//               in a small FIFO and handles redirects from execute.
// Ports       : clk, reset            - clock, asynchronous active-high reset
//               stall                 - decode not accepting this cycle
//               redirect_valid/target - taken branch/jump from execute
//               imem_addr/imem_rdata  - ROM address out, data back next cycle
//               ins_valid/out/pc/pc_plus1 - FIFO head presented to decode
//               stall_cycles, flush_count - perf counters (optional)
// Options     : FETCH_PERF_CNT_EN adds the saturating perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter int          DEPTH    = DEPTH_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              ins_valid,
  output logic [31:0]       ins_out,
  output logic [31:0]       ins_pc,
  output logic [31:0]       ins_pc_plus1
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;
  logic             pop;
  logic             issue;
  logic [CNT_W:0]   occupancy;

  assign ins_valid = (fifo_count != '0);
  assign pop       = ins_valid & ~stall;

  // Slots that will be taken after this edge; pop implies count >= 1, so
  // the subtraction cannot underflow.
  assign occupancy = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(inflight_q)
                   - (CNT_W + 1)'(pop);
  assign issue     = ~redirect_valid & (occupancy < (CNT_W + 1)'(DEPTH));

  // The ROM is always addressed from the PC; when nothing is issued the read
  // result is simply never captured.
  assign imem_addr = pc_q[ADDR_W-1:0];

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      pc_d = redirect_target;
    end else if (issue) begin
      pc_d          = pc_inc(pc_q);
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign push_entry.pc  = inflight_pc_q;
  assign push_entry.ins = imem_rdata;

  // A redirect flushes the FIFO; the flush also discards the response that
  // lands in the same cycle, which squashes the in-flight read.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Head fields read as zero while the FIFO is empty.
  assign ins_out      = ins_valid ? fifo_head.ins        : '0;
  assign ins_pc       = ins_valid ? fifo_head.pc         : '0;
  assign ins_pc_plus1 = ins_valid ? pc_inc(fifo_head.pc) : '0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (ins_valid && stall && (stall_cycles_q != '1))
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (redirect_valid && (flush_count_q != '1))
        flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  // Perf counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A ROM model answers
//               0xA000_0000 + addr one cycle after the address; a queue of
//               expected PCs is compared against every instruction decode
//               accepts, plus cycle-exact latency/addressing checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        ins_valid;
  logic [31:0] ins_out;
  logic [31:0] ins_pc;
  logic [31:0] ins_pc_plus1;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  int unsigned checks;
  int unsigned errors;
  logic [31:0] exp_q[$];

  fetch_unit #(
    .ADDR_W   (12),
    .DEPTH    (2),
    .RESET_PC (32'd0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .ins_valid       (ins_valid),
    .ins_out         (ins_out),
    .ins_pc          (ins_pc),
    .ins_pc_plus1    (ins_pc_plus1)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM model.
  always @(posedge clk) imem_rdata <= 32'hA000_0000 + {20'd0, imem_addr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(i));
  endtask

  // Everything expected before the redirect must have been consumed.
  task automatic start_redirect(input logic [31:0] tgt);
    check("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    redirect_valid  = 1'b1;
    redirect_target = tgt;
  endtask

  // Scoreboard: every accepted (and not squashed) instruction is compared.
  always @(negedge clk) begin
    if (!reset && ins_valid && !stall && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_accept", ins_pc, 32'hDEAD_BEEF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_pc", ins_pc, e);
        check("sb_ins", ins_out, 32'hA000_0000 + (e & 32'h0000_0FFF));
        check("sb_pc1", ins_pc_plus1, e + 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;

    // Reset state
    step(); step();
    @(negedge clk);
    check("rst_valid", {31'd0, ins_valid}, 32'd0);
    check("rst_out",   ins_out,      32'd0);
    check("rst_pc",    ins_pc,       32'd0);
    check("rst_pc1",   ins_pc_plus1, 32'd0);
    check("rst_addr",  {20'd0, imem_addr}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_stallcnt", stall_cycles, 32'd0);
    check("rst_flushcnt", flush_count,  32'd0);
`endif

    // 1: streaming from reset
    step();
    reset = 1'b0;
    push_range(32'd0, 4);
    @(negedge clk); check("s1_addr0", {20'd0, imem_addr}, 32'd0);
    step(); @(negedge clk); check("s1_lat1", {31'd0, ins_valid}, 32'd0);
    step(); @(negedge clk); check("s1_first_v", {31'd0, ins_valid}, 32'd1);
    check("s1_first_pc", ins_pc, 32'd0);
    step(); step(); step(); step();
    check("s1_head4_v", {31'd0, ins_valid}, 32'd1);
    check("s1_head4", ins_pc, 32'd4);

    // 2: stall for 5 cycles at pc 4
    stall = 1'b1;
    check("s1_drain", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("s2_hold_v",  {31'd0, ins_valid}, 32'd1);
      check("s2_hold_pc", ins_pc, 32'd4);
      check("s2_no_issue", {20'd0, imem_addr}, 32'd6);
      step();
    end
    stall = 1'b0;
    push_range(32'd4, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s2_rel_v",  {31'd0, ins_valid}, 32'd1);
      check("s2_rel_pc", ins_pc, 32'd4 + 32'(i));
`ifdef FETCH_PERF_CNT_EN
      if (i == 0) check("s2_stallcnt", stall_cycles, 32'd5);
`endif
      step();
    end

    // 3: redirect together with stall while the FIFO fills
    stall = 1'b1;
    start_redirect(32'h0000_0100);
    step();
    redirect_valid = 1'b0;
    stall = 1'b0;
    exp_q.push_back(32'h100);
    @(negedge clk); check("s3_flush_v", {31'd0, ins_valid}, 32'd0);
    check("s3_addr", {20'd0, imem_addr}, 32'h100);
    step(); @(negedge clk); check("s3_lat_v", {31'd0, ins_valid}, 32'd0);
    step(); @(negedge clk); check("s3_tgt_v", {31'd0, ins_valid}, 32'd1);
    check("s3_tgt_pc", ins_pc, 32'h100);
    step();

    // 4: back-to-back redirects, latest wins
    start_redirect(32'h20);
    step();
    start_redirect(32'h40);
    step();
    redirect_valid = 1'b0;
    push_range(32'h40, 3);
    @(negedge clk); check("s4_flush_v", {31'd0, ins_valid}, 32'd0);
    check("s4_addr", {20'd0, imem_addr}, 32'h40);
    step(); @(negedge clk); check("s4_lat_v", {31'd0, ins_valid}, 32'd0);
    step(); @(negedge clk); check("s4_tgt_pc", ins_pc, 32'h40);
    step(); step(); step();

    // 5: PC wrap
    start_redirect(32'hFFFF_FFFE);
    step();
    redirect_valid = 1'b0;
    exp_q.push_back(32'hFFFF_FFFE);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_0000);
    @(negedge clk); check("s5_addr0", {20'd0, imem_addr}, 32'hFFE);
    step(); @(negedge clk); check("s5_addr1", {20'd0, imem_addr}, 32'hFFF);
    step(); @(negedge clk); check("s5_addr2", {20'd0, imem_addr}, 32'h000);
    check("s5_pc0", ins_pc, 32'hFFFF_FFFE);
    step(); @(negedge clk); check("s5_pc1_wrap", ins_pc_plus1, 32'h0);
    step(); @(negedge clk);
    step();
    stall = 1'b1;
    check("s5_drain", 32'(exp_q.size()), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("s5_flushcnt", flush_count, 32'd4);
`endif

    // 6: reset with two entries buffered
    step();
    check("s6_full_pc", ins_pc, 32'd1);
    reset = 1'b1;
    #1;
    check("s6_async_v",  {31'd0, ins_valid}, 32'd0);
    check("s6_async_pc", ins_pc, 32'd0);
    @(negedge clk);
    check("s6_rst_addr", {20'd0, imem_addr}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("s6_rst_stallcnt", stall_cycles, 32'd0);
    check("s6_rst_flushcnt", flush_count,  32'd0);
`endif
    step();
    reset = 1'b0;
    stall = 1'b0;
    exp_q.delete();
    push_range(32'd0, 4);
    @(negedge clk); check("s6_lat0_v", {31'd0, ins_valid}, 32'd0);
    step(); @(negedge clk); check("s6_lat1_v", {31'd0, ins_valid}, 32'd0);
    step(); @(negedge clk); check("s6_restart_pc", ins_pc, 32'd0);
    step(); @(negedge clk);
    step(); @(negedge clk);
    step(); @(negedge clk);
    step();
    stall = 1'b1;
    check("s6_drain", 32'(exp_q.size()), 32'd0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
